// File: rtl/dot_pkg.sv
// Shared definitions for the 8x8 dot-matrix display blocks.
package dot_pkg;

  localparam int DOT_ROWS = 8;
  localparam int DOT_COLS = 8;

  // One row of column pixels; bit 7 is the leftmost column.
  typedef logic [DOT_COLS-1:0] row_pat_t;

  // All rows deselected on the active-low row bus.
  localparam row_pat_t ROW_OFF = 8'hFF;

  // Frame-store state: ACCEPT takes writes, PENDING waits for the frame boundary.
  typedef enum logic {
    ACCEPT  = 1'b0,
    PENDING = 1'b1
  } scan_state_t;

endpackage

// File: rtl/dot_row_decoder.sv
// 3-bit row index to active-low one-hot row select.
// Row 0 drives bit 7 low; row 7 drives bit 0 low.
module dot_row_decoder
  import dot_pkg::*;
(
  input  logic [2:0] row_idx,
  output logic [7:0] row_sel
);

  genvar gi;
  generate
    for (gi = 0; gi < DOT_ROWS; gi++) begin : g_row
      assign row_sel[DOT_ROWS-1-gi] = (row_idx != 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/dot_frame_scan_ctrl.sv
// Double-buffered frame store and row-multiplexed scan for the 8x8 LED matrix.
// Upstream writes land in the back buffer; a commit copies back to front at the
// next frame boundary so the visible picture never tears.
// Optional build macro: DOT_BLANK_EN -- blank the columns on the first cycle of
// every row to suppress ghosting between adjacent rows.
module dot_frame_scan_ctrl
  import dot_pkg::*;
#(
  parameter int ROW_HOLD = 4,
  parameter int HOLD_W   = $clog2(ROW_HOLD)
) (
  input  logic       div_clk,
  input  logic       reset,
  input  logic       en,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output logic       swap_pending,
  output logic       frame_done,
  output logic [7:0] dot_row,
  output logic [7:0] dot_col
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ROW_HOLD - 1);
  localparam logic [2:0]        ROW_LAST  = 3'(DOT_ROWS - 1);

  scan_state_t                           state_reg;
  logic                                  wr_ready_reg;
  logic                                  swap_pending_reg;
  logic                                  frame_done_reg;
  logic [HOLD_W-1:0]                     hold_cnt_reg;
  logic [2:0]                            row_idx_reg;
  logic [7:0]                            dot_row_reg;
  logic [7:0]                            dot_col_reg;
  logic [DOT_ROWS-1:0][DOT_COLS-1:0]     back_reg;
  logic [DOT_ROWS-1:0][DOT_COLS-1:0]     front_reg;
  logic [DOT_ROWS-1:0][DOT_COLS-1:0]     back_next;
  logic [7:0]                            row_sel;
  logic                                  row_last_cycle;
  logic                                  boundary;
  logic                                  wr_fire;
  logic                                  swap_fire;

  assign row_last_cycle = en && (hold_cnt_reg == HOLD_LAST);
  assign boundary       = row_last_cycle && (row_idx_reg == ROW_LAST);
  assign wr_fire        = wr_valid && wr_ready_reg;
  // A commit landing exactly on the boundary edge swaps immediately.
  assign swap_fire      = boundary && ((state_reg == PENDING) || commit);

  // Back buffer as it will look after this cycle's write, so a write issued
  // together with a commit is part of the swapped frame.
  genvar gi;
  generate
    for (gi = 0; gi < DOT_ROWS; gi++) begin : g_back_next
      assign back_next[gi] = (wr_fire && (wr_row == 3'(gi))) ? wr_data : back_reg[gi];
    end
  endgenerate

  dot_row_decoder u_row_decoder (
    .row_idx (row_idx_reg),
    .row_sel (row_sel)
  );

  // Frame store: back buffer takes accepted writes, front buffer copies on swap.
  always_ff @(posedge div_clk or negedge reset) begin
    if (!reset) begin
      back_reg  <= '0;
      front_reg <= '0;
    end else begin
      back_reg <= back_next;
      if (swap_fire) begin
        front_reg <= back_next;
      end
    end
  end

  // Dwell and row counters; frozen while the scan is disabled.
  always_ff @(posedge div_clk or negedge reset) begin
    if (!reset) begin
      hold_cnt_reg   <= '0;
      row_idx_reg    <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= boundary;
      if (en) begin
        if (row_last_cycle) begin
          hold_cnt_reg <= '0;
          row_idx_reg  <= row_idx_reg + 3'd1;
        end else begin
          hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
        end
      end
    end
  end

  // Swap handshake FSM with registered ready/pending flags.
  always_ff @(posedge div_clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= ACCEPT;
      wr_ready_reg     <= 1'b1;
      swap_pending_reg <= 1'b0;
    end else begin
      case (state_reg)
        ACCEPT: begin
          if (commit && !boundary) begin
            state_reg        <= PENDING;
            wr_ready_reg     <= 1'b0;
            swap_pending_reg <= 1'b1;
          end
        end
        PENDING: begin
          if (boundary) begin
            state_reg        <= ACCEPT;
            wr_ready_reg     <= 1'b1;
            swap_pending_reg <= 1'b0;
          end
        end
        default: begin
          state_reg        <= ACCEPT;
          wr_ready_reg     <= 1'b1;
          swap_pending_reg <= 1'b0;
        end
      endcase
    end
  end

  // Display pins: current row and its front-buffer pixels, blanked when disabled.
  always_ff @(posedge div_clk or negedge reset) begin
    if (!reset) begin
      dot_row_reg <= ROW_OFF;
      dot_col_reg <= '0;
    end else if (en) begin
      dot_row_reg <= row_sel;
`ifdef DOT_BLANK_EN
      dot_col_reg <= (hold_cnt_reg == '0) ? '0 : front_reg[row_idx_reg];
`else
      dot_col_reg <= front_reg[row_idx_reg];
`endif
    end else begin
      dot_row_reg <= ROW_OFF;
      dot_col_reg <= '0;
    end
  end

  assign wr_ready     = wr_ready_reg;
  assign swap_pending = swap_pending_reg;
  assign frame_done   = frame_done_reg;
  assign dot_row      = dot_row_reg;
  assign dot_col      = dot_col_reg;

endmodule
